// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle done pulse.
// Define COUNTDOWN_TIMER_RELOAD_EN to restart from the last loaded value after each DONE.
module countdown_timer #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;

`ifdef COUNTDOWN_TIMER_RELOAD_EN
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] reload_nxt;
`endif

   // State, count and decoded status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
`ifdef COUNTDOWN_TIMER_RELOAD_EN
         reload <= reload_nxt;
`endif
      end
   end

   // Next-state logic; load overrides every state
   always_comb begin
      state_nxt = state;
      count_nxt = count;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
      reload_nxt = reload;
`endif
      if (load) begin
         state_nxt = IDLE;
         count_nxt = load_val;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
         reload_nxt = load_val;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = (count == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               // RUN is only entered with a nonzero count, so the zero guard never fires
               if (en) begin
                  if (count == WIDTH'(1)) begin
                     count_nxt = '0;
                     state_nxt = DONE;
                  end else if (count != '0) begin
                     count_nxt = count - WIDTH'(1);
                  end
               end
            end
            DONE: begin
`ifdef COUNTDOWN_TIMER_RELOAD_EN
               if (reload != '0) begin
                  count_nxt = reload;
                  state_nxt = RUN;
               end else begin
                  count_nxt = '0;
                  state_nxt = IDLE;
               end
`else
               count_nxt = '0;
               state_nxt = IDLE;
`endif
            end
            default: begin
               state_nxt = IDLE;
               count_nxt = '0;
            end
         endcase
      end
   end

   assign zero = (count == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_countdown_timer;

   localparam int unsigned W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic         zero;

   int checks = 0;
   int passed = 0;

   // Behavioural model
   int m_count  = 0;
   int m_reload = 0;
   bit m_run    = 1'b0;
   bit m_done   = 1'b0;

   countdown_timer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .en       (en),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   // Drive inputs, take one rising edge, advance the model, settle for sampling
   task automatic tick(input bit r, input bit l, input int lv, input bit s, input bit e);
      rst      = r;
      load     = l;
      load_val = W'(lv);
      start    = s;
      en       = e;
      @(posedge clk);
      if (r) begin
         m_count = 0; m_reload = 0; m_run = 0; m_done = 0;
      end else if (l) begin
         m_count = lv; m_reload = lv; m_run = 0; m_done = 0;
      end else if (m_done) begin
         m_done = 0;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
         if (m_reload != 0) begin
            m_count = m_reload; m_run = 1;
         end else begin
            m_count = 0; m_run = 0;
         end
`else
         m_count = 0; m_run = 0;
`endif
      end else if (m_run) begin
         if (e) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_run = 0; m_done = 1;
            end
         end
      end else if (s) begin
         if (m_count == 0) m_done = 1;
         else m_run = 1;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1, 1, 5, 1, 1);
         checks++;
         if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1)
            $display("FAIL reset[%0d]: count=%0d busy=%b done=%b zero=%b, expected 0/0/0/1",
                     i, count, busy, done, zero);
         else passed++;
      end
   endtask

   task automatic test_countdown();
      tick(0, 1, 5, 0, 0);
      checks++;
      if (count !== 3'd5 || busy !== 1'b0) $display("FAIL cd_load: count=%0d busy=%b, expected 5/0", count, busy);
      else passed++;
      tick(0, 0, 0, 1, 1);
      checks++;
      if (count !== 3'd5 || busy !== 1'b1 || done !== 1'b0)
         $display("FAIL cd_start: count=%0d busy=%b done=%b, expected 5/1/0", count, busy, done);
      else passed++;
      for (int j = 1; j <= 5; j++) begin
         tick(0, 0, 0, 0, 1);
         checks++;
         if (count !== W'(5 - j) || done !== (j == 5) || busy !== (j < 5))
            $display("FAIL cd_step%0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                     j, count, busy, done, 5 - j, j < 5, j == 5);
         else passed++;
      end
      tick(0, 0, 0, 0, 1);
      checks++;
      if (count !== W'(m_count) || busy !== m_run || done !== 1'b0)
         $display("FAIL cd_after: count=%0d busy=%b done=%b, expected %0d/%b/0", count, busy, done, m_count, m_run);
      else passed++;
`ifndef COUNTDOWN_TIMER_RELOAD_EN
      checks++;
      if (busy !== 1'b0 || count !== '0) $display("FAIL cd_idle: busy=%b count=%0d, expected 0/0", busy, count);
      else passed++;
`endif
   endtask

   task automatic test_pause();
      int edges = 0;
      bit e;
      tick(0, 1, 7, 0, 0);
      tick(0, 0, 0, 1, 1);
      while (done !== 1'b1 && edges < 30) begin
         e = !(edges >= 2 && edges < 6);
         tick(0, 0, 0, 0, e);
         edges++;
         if (!e) begin
            checks++;
            if (count !== 3'd5 || busy !== 1'b1)
               $display("FAIL pause_hold: count=%0d busy=%b, expected 5/1", count, busy);
            else passed++;
         end
      end
      checks++;
      if (edges != 11 || count !== '0) $display("FAIL pause_latency: edges=%0d count=%0d, expected 11/0", edges, count);
      else passed++;
      tick(0, 1, 0, 0, 0);
   endtask

   task automatic test_zero_start();
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 0, 1, 1);
      checks++;
      if (done !== 1'b1 || count !== '0 || busy !== 1'b0 || zero !== 1'b1)
         $display("FAIL zs_done: done=%b count=%0d busy=%b zero=%b, expected 1/0/0/1", done, count, busy, zero);
      else passed++;
      tick(0, 0, 0, 0, 1);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== '0)
         $display("FAIL zs_after: done=%b busy=%b count=%0d, expected 0/0/0", done, busy, count);
      else passed++;
   endtask

   task automatic test_abort();
      tick(0, 1, 4, 0, 0);
      tick(0, 0, 0, 1, 1);
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 1);
      tick(0, 1, 6, 0, 1);
      checks++;
      if (count !== 3'd6 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL abort_load: count=%0d busy=%b done=%b, expected 6/0/0", count, busy, done);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 0, 1);
         checks++;
         if (count !== 3'd6 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_idle[%0d]: count=%0d busy=%b done=%b, expected 6/0/0", i, count, busy, done);
         else passed++;
      end
      tick(0, 0, 0, 1, 1);
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 1);
      checks++;
      if (count !== '0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL abort_rst: count=%0d busy=%b done=%b, expected 0/0/0", count, busy, done);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 0, 1);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_rst_quiet[%0d]: busy=%b done=%b, expected 0/0", i, busy, done);
         else passed++;
      end
   endtask

`ifdef COUNTDOWN_TIMER_RELOAD_EN
   task automatic test_reload();
      tick(0, 1, 3, 0, 0);
      tick(0, 0, 0, 1, 1);
      for (int j = 1; j <= 12; j++) begin
         tick(0, 0, 0, 0, 1);
         checks++;
         if (count !== W'(3 - (j % 4)) || done !== ((j % 4) == 3))
            $display("FAIL reload_step%0d: count=%0d done=%b, expected %0d/%b",
                     j, count, done, 3 - (j % 4), (j % 4) == 3);
         else passed++;
      end
      tick(0, 1, 0, 0, 0);
   endtask
`endif

   task automatic test_random();
      bit r, l, s, e;
      int lv;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 49) == 0);
         l  = ($urandom_range(0, 9) == 0);
         s  = ($urandom_range(0, 4) == 0);
         e  = ($urandom_range(0, 9) < 7);
         lv = int'($urandom_range(0, 7));
         tick(r, l, lv, s, e);
         checks++;
         if (count !== W'(m_count)) $display("FAIL rnd_count[%0d]: got %0d, expected %0d", i, count, m_count);
         else passed++;
         checks++;
         if (busy !== m_run) $display("FAIL rnd_busy[%0d]: got %b, expected %b", i, busy, m_run);
         else passed++;
         checks++;
         if (done !== m_done) $display("FAIL rnd_done[%0d]: got %b, expected %b", i, done, m_done);
         else passed++;
         checks++;
         if (zero !== (m_count == 0)) $display("FAIL rnd_zero[%0d]: got %b, expected %b", i, zero, m_count == 0);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_pause();
      test_zero_start();
      test_abort();
`ifdef COUNTDOWN_TIMER_RELOAD_EN
      test_reload();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1 bit, load request for load_val.
REQ-005 SHALL have port load_val, input, WIDTH bits, start value for the countdown.
REQ-006 SHALL have port start, input, 1 bit, begin countdown request.
REQ-007 SHALL have port en, input, 1 bit, decrement enable while running; low pauses the countdown.
REQ-008 SHALL have port count, output, WIDTH bits, registered current count.
REQ-009 SHALL have port busy, output, 1 bit, high while in RUN.
REQ-010 SHALL have port done, output, 1 bit, registered one-cycle terminal pulse.
REQ-011 SHALL have port zero, output, 1 bit, combinational (count == 0).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encoding is free.
REQ-013 Priority at each edge SHALL be: rst > load > state-specific behaviour.
REQ-014 Load:
- load=1 in any state: count <= load_val, reload register <= load_val, state <= IDLE.
- A load in RUN or DONE aborts the countdown with no done pulse.
REQ-015 IDLE, start=1, count != 0: state <= RUN; count unchanged at that edge.
REQ-016 IDLE, start=1, count == 0: state <= DONE directly (done pulse with no countdown).
REQ-017 IDLE, start=0: hold all state.
REQ-018 RUN, en=1, count > 1: count <= count - 1.
REQ-019 RUN, en=1, count == 1: count <= 0 and state <= DONE.
REQ-020 RUN, en=0: hold count and state.
REQ-021 start SHALL be ignored in RUN and DONE.
REQ-022 done SHALL be 1 exactly for the cycle the FSM is in DONE, otherwise 0.
REQ-023 DONE SHALL last exactly one cycle; the exit transition is defined under Configuration.
REQ-024 Latency: with count=N (N>=1) and en held high, start sampled at edge k:
- RUN from edge k;
- count = N-j after edge k+j;
- count = 0 and done = 1 after edge k+N.
REQ-025 Decrement SHALL be modulo 2^WIDTH arithmetic, but the FSM SHALL never decrement from 0 (no wrap to all-ones).
REQ-026 busy SHALL equal (state == RUN).

Reset
REQ-027 rst=1 at an edge SHALL force: count=0, reload register=0, state=IDLE, busy=0, done=0; this overrides load, start and en.
REQ-028 rst asserted mid-countdown SHALL abort without a done pulse.

Configuration
REQ-029 SHALL support macro COUNTDOWN_TIMER_RELOAD_EN.
REQ-030 Without the macro:
- DONE exits to IDLE with count = 0.
- The reload register MAY be omitted.
REQ-031 With the macro:
- DONE exits by setting count <= reload register and state <= RUN, giving a periodic done every N+1 cycles with en high.
- If the reload register is 0, DONE exits to IDLE.
- load still aborts to IDLE per REQ-014.

Verification (WIDTH=3)
REQ-032 rst=1 for 3 edges with load=1, start=1 -> count=0, busy=0, done=0, zero=1.
REQ-033 load 5, then start, en=1 -> count 5,4,3,2,1,0 on successive edges; done=1 exactly one cycle when count=0; busy=0 afterwards (macro off).
REQ-034 load 7, start, en=0 for 4 cycles mid-run -> count holds, busy stays 1; total done latency = 7 + 4 cycles.
REQ-035 load 0, start -> done=1 on the next cycle, count stays 0, busy never 1.
REQ-036 load 4, start, then load 6 after 2 decrements -> count=6, state IDLE, no done pulse; rst mid-run -> count=0, no done pulse.
REQ-037 Macro on, load 3, start, en=1 -> done pulses every 4 cycles, count sequence 3,2,1,0,3,2,1,0...
